// File: rtl/thermal_encoder_stream.sv
// Streaming thermometer / one-hot pixel encoder: one pixel per cycle in, PIXELS_PER_WORD
// codes packed per output word, with frame-end flush and a sticky frame-length error.
module thermal_encoder_stream #(
    parameter int DATA_WIDTH      = 8,
    parameter int LEVELS          = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int FRAME_PIXELS    = 784,
    localparam int OUT_WIDTH      = LEVELS * PIXELS_PER_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  in_last,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  encoded_out,
    output logic                  out_last,
    output logic                  frame_err
);

    localparam int STEP   = (1 << DATA_WIDTH) / LEVELS;
    localparam int THR_W  = DATA_WIDTH + 1;
    localparam int SLOT_W = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
    localparam int CNT_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    logic [LEVELS-1:0]    ge;
    logic [LEVELS-1:0]    onehot;
    logic [LEVELS-1:0]    code;
    logic [OUT_WIDTH-1:0] pack_q;
    logic [OUT_WIDTH-1:0] merged;
    logic [SLOT_W-1:0]    slot_q;
    logic [CNT_W-1:0]     pix_cnt_q;
    logic                 accept;
    logic                 cnt_at_end;
    logic                 frame_end;
    logic                 word_done;

    // Handshake: a pixel moves on in_valid && in_ready, a word on out_valid && out_ready;
    // the output register only refills when empty or being drained this same cycle, and
    // encoded_out/out_last are held while out_valid && !out_ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Thresholds are compared one bit wider so k*STEP = 2^DATA_WIDTH can never match.
    always_comb begin
        ge = '0;
        for (int k = 0; k < LEVELS; k++) begin
            ge[k] = ({1'b0, pixel_in} >= THR_W'((k + 1) * STEP));
        end
    end

    // The thermometer vector is monotonic, so its top set bit alone is the one-hot code.
    assign onehot = ge & ~{1'b0, ge[LEVELS-1:1]};
    assign code   = mode ? onehot : ge;

    assign cnt_at_end = (pix_cnt_q == CNT_W'(FRAME_PIXELS - 1));
    assign frame_end  = in_last || cnt_at_end;
    assign word_done  = (slot_q == SLOT_W'(PIXELS_PER_WORD - 1)) || frame_end;

    always_comb begin
        merged = pack_q;
        merged[int'(slot_q) * LEVELS +: LEVELS] = code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            encoded_out <= '0;
            out_last    <= 1'b0;
            frame_err   <= 1'b0;
            pack_q      <= '0;
            slot_q      <= '0;
            pix_cnt_q   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                // A load on the same edge as a consume overrides the clear above.
                if (word_done) begin
                    out_valid   <= 1'b1;
                    encoded_out <= merged;
                    out_last    <= frame_end;
                    pack_q      <= '0;
                    slot_q      <= '0;
                end else begin
                    pack_q <= merged;
                    slot_q <= slot_q + 1'b1;
                end
                pix_cnt_q <= frame_end ? '0 : pix_cnt_q + 1'b1;
                if (in_last != cnt_at_end) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_thermal_encoder_stream.sv
// Bench for thermal_encoder_stream: a reference model pushes expected words to a queue as
// pixels are accepted; a negedge monitor pops and compares each transferred word.
module tb_thermal_encoder_stream;

    localparam int DW    = 8;
    localparam int LV    = 8;
    localparam int PPW   = 4;
    localparam int FP    = 6;
    localparam int OUT_W = LV * PPW;
    localparam int STEP  = (1 << DW) / LV;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    pixel_in;
    logic             in_last;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] encoded_out;
    logic             out_last;
    logic             frame_err;

    thermal_encoder_stream #(
        .DATA_WIDTH(DW),
        .LEVELS(LV),
        .PIXELS_PER_WORD(PPW),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pixel_in(pixel_in),
        .in_last(in_last),
        .mode(mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .encoded_out(encoded_out),
        .out_last(out_last),
        .frame_err(frame_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    logic [OUT_W+1:0] exp_q[$];   // {frame_err, out_last, word}
    logic [OUT_W-1:0] m_pack;
    int               m_slot;
    int               m_cnt;
    bit               m_err;
    int               n_checks;
    int               n_fail;
    int               release_after;

    function automatic logic [LV-1:0] model_code(input int p, input bit m);
        int          n;
        logic [31:0] t;
        n = 0;
        for (int k = 1; k <= LV; k++) begin
            if (p >= k * STEP) n++;
        end
        if (m) t = (n == 0) ? 32'd0 : (32'd1 << (n - 1));
        else   t = (32'd1 << n) - 32'd1;
        return t[LV-1:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_pack = '0;
        m_slot = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_accept(input int p, input bit m, input bit l);
        bit fend;
        m_pack[m_slot*LV +: LV] = model_code(p, m);
        fend = l || (m_cnt == FP - 1);
        if (l != (m_cnt == FP - 1)) m_err = 1'b1;
        if (m_slot == PPW - 1 || fend) begin
            exp_q.push_back({m_err, fend, m_pack});
            m_pack = '0;
            m_slot = 0;
        end else begin
            m_slot++;
        end
        m_cnt = fend ? 0 : m_cnt + 1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [OUT_W+1:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got word=%h last=%b err=%b, expected no word",
                         encoded_out, out_last, frame_err);
            end else begin
                e = exp_q.pop_front();
                if ({frame_err, out_last, encoded_out} !== e) begin
                    n_fail++;
                    $display("FAIL word: got word=%h last=%b err=%b, expected word=%h last=%b err=%b",
                             encoded_out, out_last, frame_err, e[OUT_W-1:0], e[OUT_W], e[OUT_W+1]);
                end
            end
        end
    end

    // ---------------- driver tasks (entered #1 after a rising edge) ----------------
    task automatic send(input int p, input bit m, input bit l);
        int waits;
        waits    = 0;
        pixel_in = p[DW-1:0];
        mode     = m;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
            if (release_after >= 0 && waits >= release_after) out_ready = 1'b1;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", waits);
            in_valid = 1'b0;
        end else begin
            model_accept(p, m, l);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waits;
        waits     = 0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        while (exp_q.size() != 0 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        pixel_in  = '0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (encoded_out !== '0) begin n_fail++; $display("FAIL reset_encoded: got %h expected 0", encoded_out); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        release_reset();
    endtask

    task automatic test_thermometer();
        send(0, 1'b0, 1'b0);
        send(32, 1'b0, 1'b0);
        send(100, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL therm_early_valid: got %b expected 0", out_valid); end
        send(255, 1'b0, 1'b0);
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL therm_latency: got out_valid=%b expected 1", out_valid); end
        if (encoded_out !== exp_q[0][OUT_W-1:0]) begin
            n_fail++; $display("FAIL therm_word: got %h expected %h", encoded_out, exp_q[0][OUT_W-1:0]);
        end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL therm_last: got %b expected 0", out_last); end
        send(10, 1'b0, 1'b0);
        send(200, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_onehot();
        send(31, 1'b1, 1'b0);
        send(64, 1'b1, 1'b0);
        send(100, 1'b1, 1'b0);
        send(255, 1'b1, 1'b0);
        n_checks++;
        if (encoded_out !== 32'h40040200) begin
            n_fail++; $display("FAIL onehot_word: got %h expected 40040200", encoded_out);
        end
        send(128, 1'b0, 1'b0);
        send(50, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        out_ready = 1'b0;
        send(40, 1'b0, 1'b0);
        send(80, 1'b1, 1'b0);
        send(120, 1'b0, 1'b0);
        send(160, 1'b1, 1'b0);
        held     = encoded_out;
        pixel_in = 8'd250;
        in_valid = 1'b1;
        n_checks++;
        if (held !== exp_q[0][OUT_W-1:0]) begin
            n_fail++; $display("FAIL bp_word: got %h expected %h", held, exp_q[0][OUT_W-1:0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
            if (encoded_out !== held) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", encoded_out, held); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(250, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got out_valid=%b expected 0", out_valid); end
        send(7, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_short_frame();
        for (int i = 0; i < FP; i++) send(200, 1'b0, i == FP - 1);
        n_checks += 3;
        if (encoded_out !== 32'h00003F3F) begin n_fail++; $display("FAIL short_word: got %h expected 00003f3f", encoded_out); end
        if (out_last !== 1'b1) begin n_fail++; $display("FAIL short_last: got %b expected 1", out_last); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL short_err: got %b expected 0", frame_err); end
        drain();
    endtask

    task automatic test_frame_err();
        for (int i = 0; i < 3; i++) send(200, 1'b0, i == 2);
        n_checks += 3;
        if (encoded_out !== 32'h003F3F3F) begin n_fail++; $display("FAIL early_last_word: got %h expected 003f3f3f", encoded_out); end
        if (out_last !== 1'b1) begin n_fail++; $display("FAIL early_last_flag: got %b expected 1", out_last); end
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL early_last_err: got %b expected 1", frame_err); end
        for (int i = 0; i < FP; i++) send(30 * i, 1'b0, i == FP - 1);
        drain();
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", frame_err); end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_clear();
        release_reset();
        for (int i = 0; i < FP; i++) send(200, 1'b0, 1'b0);
        n_checks += 2;
        if (out_last !== 1'b1) begin n_fail++; $display("FAIL missing_last_flag: got %b expected 1", out_last); end
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL missing_last_err: got %b expected 1", frame_err); end
        drain();
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b0;
        for (int i = 0; i < PPW; i++) send(100, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pending_valid: got %b expected 0", out_valid); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b expected 0", frame_err); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        model_clear();
        out_ready = 1'b1;
        release_reset();
        send(250, 1'b1, 1'b0);
        send(90, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_partial_valid: got %b expected 0", out_valid); end
        model_clear();
        release_reset();
        for (int i = 0; i < PPW; i++) send(200, 1'b0, 1'b0);
        n_checks++;
        if (encoded_out !== 32'h3F3F3F3F) begin n_fail++; $display("FAIL rst_residue: got %h expected 3f3f3f3f", encoded_out); end
        send(70, 1'b0, 1'b0);
        send(70, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FP; i++) begin
                release_after = $urandom_range(1, 3);
                out_ready     = 1'($urandom_range(0, 1));
                send($urandom_range(0, 255), 1'($urandom_range(0, 1)), i == FP - 1);
            end
        end
        release_after = -1;
        drain();
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL random_err: got %b expected 0", frame_err); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        release_after = -1;
        test_reset();
        test_thermometer();
        test_onehot();
        test_backpressure();
        test_short_frame();
        test_reset_mid_word();
        test_random();
        test_frame_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
